// File: rtl/dmem_access_seq.sv
// dmem_access_seq: core load/store and loader byte-write sequencer
// for a single-port, byte-wide, 1-cycle-latency data SRAM.
module dmem_access_seq #(
    parameter int BIN_DIG    = 32,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [BIN_DIG-1:0]    req_addr,
    input  logic [BIN_DIG-1:0]    req_wdata,
    output logic                  rsp_valid,
    output logic [BIN_DIG-1:0]    rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [MEM_ADDR_W-1:0] ld_addr,
    input  logic [7:0]            ld_wdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BEAT   = 3'd1;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic LG_CORE   = 1'b0;
    localparam logic LG_LOADER = 1'b1;

    logic [2:0]            state;
    logic                  last_grant;
    logic                  c_we;
    logic [2:0]            c_f3;
    logic [MEM_ADDR_W-1:0] c_addr;
    logic [31:0]           c_wdata;
    logic [1:0]            cnt;
    logic [1:0]            last_cnt;
    logic                  pend;
    logic [1:0]            lane_q;
    logic [31:0]           rd_buf;
    logic [31:0]           word;
    logic [BIN_DIG-1:0]    ext;
    logic [BIN_DIG-1:0]    rdata_q;
    logic                  idle;
    logic                  core_gnt;
    logic                  ld_gnt;
    logic                  misalign;
    logic                  out_rng;
    logic                  req_err;

    assign idle     = (state == S_IDLE) && !RST;
    assign core_gnt = idle && req_valid
                      && (!ld_valid || last_grant == LG_LOADER);
    assign ld_gnt   = idle && ld_valid
                      && (!req_valid || last_grant == LG_CORE);

    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0])
                      || (req_funct3[1:0] == 2'b10
                          && req_addr[1:0] != 2'b00);
    assign out_rng  = |req_addr[BIN_DIG-1:MEM_ADDR_W];
    assign req_err  = (req_funct3[1:0] == 2'b11) || misalign || out_rng;

    assign req_ready = core_gnt;
    assign ld_ready  = ld_gnt;
    assign rsp_valid = (state == S_RESP) || (state == S_ERR);
    assign rsp_err   = (state == S_ERR);
    assign rsp_rdata = rdata_q;
    assign busy      = (state != S_IDLE);

    // Index of the final beat for the captured access size.
    always_comb begin
        last_cnt = 2'd3;
        unique case (c_f3[1:0])
            2'b00:   last_cnt = 2'd0;
            2'b01:   last_cnt = 2'd1;
            default: last_cnt = 2'd3;
        endcase
    end

    // Load word with the byte arriving this cycle merged in.
    always_comb begin
        word = rd_buf;
        if (pend) begin
            word[{lane_q, 3'b000} +: 8] = mem_rdata;
        end
    end

    // Sign or zero extension of the assembled load.
    always_comb begin
        ext = '0;
        unique case (c_f3[1:0])
            2'b00: ext = c_f3[2] ? BIN_DIG'(word[7:0])
                       : {{(BIN_DIG-8){word[7]}}, word[7:0]};
            2'b01: ext = c_f3[2] ? BIN_DIG'(word[15:0])
                       : {{(BIN_DIG-16){word[15]}}, word[15:0]};
            default: ext = BIN_DIG'(word);
        endcase
    end

    // SRAM port mux: loader grant in IDLE, else core beats.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (state == S_BEAT) begin
            mem_en    = 1'b1;
            mem_we    = c_we;
            mem_addr  = c_addr + MEM_ADDR_W'(cnt);
            mem_wdata = c_we ? c_wdata[{cnt, 3'b000} +: 8] : 8'h00;
        end
    end

    // Collect load bytes one cycle after each read beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend   <= 1'b0;
            lane_q <= 2'd0;
            rd_buf <= '0;
        end else begin
            pend   <= (state == S_BEAT) && !c_we;
            lane_q <= cnt;
            if (pend) begin
                rd_buf[{lane_q, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

    // Control FSM, arbitration history and request capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            last_grant <= LG_LOADER;
            c_we       <= 1'b0;
            c_f3       <= 3'd0;
            c_addr     <= '0;
            c_wdata    <= '0;
            cnt        <= 2'd0;
            rdata_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (core_gnt) begin
                        last_grant <= LG_CORE;
                        c_we       <= req_we;
                        c_f3       <= req_funct3;
                        c_addr     <= req_addr[MEM_ADDR_W-1:0];
                        c_wdata    <= req_wdata[31:0];
                        cnt        <= 2'd0;
                        if (req_err) begin
                            state   <= S_ERR;
                            rdata_q <= '0;
                        end else begin
                            state <= S_BEAT;
                        end
                    end else if (ld_gnt) begin
                        last_grant <= LG_LOADER;
                    end
                end
                S_BEAT: begin
                    if (cnt == last_cnt) begin
                        if (c_we) begin
                            state   <= S_RESP;
                            rdata_q <= '0;
                        end else begin
                            state <= S_RDWAIT;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_RDWAIT: begin
                    rdata_q <= ext;
                    state   <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_seq.sv
// tb_dmem_access_seq: directed stimulus with a transaction-level
// reference model compared against the DUT every cycle.
module tb_dmem_access_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [11:0] ld_addr = '0;
    logic [7:0]  ld_wdata = '0;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    dmem_access_seq #(.BIN_DIG(32), .MEM_ADDR_W(12)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [7:0] sram [0:4095];
    always @(posedge CLK) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // reference model state
    logic [7:0]  ref_mem [0:4095];
    bit          m_act = 0;
    int          m_acc = 0;
    int          m_n = 0;
    int          m_rsp = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    logic [11:0] m_base = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_held = '0;
    bit          m_last_ld = 1;
    int          m_core_cnt = 0;
    int          m_ld_cnt = 0;
    int          m_first_core = 0;
    int          m_last_core_cyc = 0;
    int          m_last_ld_cyc = 0;
    int          obs_cnt = 0;
    logic [31:0] obs_rd = '0;
    logic        obs_err = 1'b0;
    int          obs_cyc = 0;

    function automatic logic [31:0] ld_expect(input logic [2:0] f3,
                                              input logic [11:0] a);
        logic [31:0] v;
        logic [31:0] lim;
        int n;
        n = 1 << f3[1:0];
        v = 0;
        for (int k = 0; k < n; k++)
            v = v | ({24'h0, ref_mem[12'(a + k)]} << (8 * k));
        if (!f3[2] && n < 4) begin
            lim = 32'd1 << (8 * n - 1);
            if (v >= lim) v = v - 2 * lim;
        end
        return v;
    endfunction

    // per-cycle model step and comparison
    initial begin
        bit idle, gc, gl, e_en, e_we, e_rv;
        logic [11:0] e_addr;
        logic [7:0] e_wd;
        int bi;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        forever begin
            @(negedge CLK);
            if (RST) begin
                m_act = 0;
                m_last_ld = 1;
                m_held = '0;
            end else begin
                idle = !m_act || cyc > m_rsp;
                gc = idle && req_valid && (!ld_valid || m_last_ld);
                gl = idle && ld_valid && (!req_valid || !m_last_ld);
                e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
                if (gl) begin
                    e_en = 1; e_we = 1;
                    e_addr = ld_addr; e_wd = ld_wdata;
                end else if (!idle && !m_err && cyc > m_acc
                             && cyc <= m_acc + m_n) begin
                    bi = cyc - m_acc - 1;
                    e_en = 1; e_we = m_we;
                    e_addr = 12'(m_base + bi);
                    e_wd = 8'(m_wd >> (8 * bi));
                end
                e_rv = !idle && cyc == m_rsp;
                if (e_rv) m_held = m_exp;
                chk("req_ready", req_ready, gc);
                chk("ld_ready", ld_ready, gl);
                chk("busy", busy, !idle);
                chk("rsp_valid", rsp_valid, e_rv);
                chk("rsp_rdata", rsp_rdata, m_held);
                chk("mem_en", mem_en, e_en);
                if (e_rv) chk("rsp_err", rsp_err, m_err);
                if (e_en) begin
                    chk("mem_we", mem_we, e_we);
                    chk("mem_addr", mem_addr, e_addr);
                    if (e_we) chk("mem_wdata", mem_wdata, e_wd);
                end
                if (rsp_valid) begin
                    obs_cnt++;
                    obs_rd = rsp_rdata;
                    obs_err = rsp_err;
                    obs_cyc = cyc;
                end
                if (e_en && e_we) ref_mem[e_addr] = e_wd;
                if (gc) begin
                    m_act = 1;
                    m_acc = cyc;
                    m_we = req_we;
                    m_base = req_addr[11:0];
                    m_wd = req_wdata;
                    m_n = 1 << req_funct3[1:0];
                    m_err = (req_funct3[1:0] == 2'b11)
                         || (req_funct3[1:0] == 2'b01 && req_addr % 2 != 0)
                         || (req_funct3[1:0] == 2'b10 && req_addr % 4 != 0)
                         || (req_addr > 32'hFFF);
                    m_rsp = cyc + (m_err ? 1 : (m_we ? m_n + 1 : m_n + 2));
                    m_exp = (m_err || m_we) ? '0
                          : ld_expect(req_funct3, req_addr[11:0]);
                    m_last_ld = 0;
                    m_core_cnt++;
                    if (m_core_cnt == 1) m_first_core = cyc;
                    m_last_core_cyc = cyc;
                end
                if (gl) begin
                    m_last_ld = 1;
                    m_ld_cnt++;
                    m_last_ld_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK); #1;
            if (!m_act || cyc > m_rsp) return;
        end
        note_fail("wait_idle");
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit scr, output logic [31:0] rd,
                          output logic er, output int lat);
        int n0, r0;
        bit got;
        wait_idle();
        n0 = m_core_cnt;
        r0 = obs_cnt;
        req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK); #1;
            if (m_core_cnt != n0) begin got = 1; break; end
        end
        if (!got) note_fail("accept");
        @(posedge CLK); #1;
        req_valid = 1'b0;
        if (scr) begin
            req_addr = addr ^ 32'h0000_0FF5;
            req_wdata = 32'hDEAD_BEEF;
            req_we = ~we;
            req_funct3 = ~f3;
        end
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK); #1;
            if (obs_cnt != r0) begin got = 1; break; end
        end
        if (!got) note_fail("response");
        rd = obs_rd;
        er = obs_err;
        lat = obs_cyc - m_last_core_cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        int a;
        int r0;
        bit done;

        // requests from both sides held through reset
        RST = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h31; req_wdata = 32'h11;
        ld_valid = 1'b1; ld_addr = 12'h030; ld_wdata = 8'h5A;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ld_ready", ld_ready, 0);
        RST = 1'b0;
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(posedge CLK); #1;
            if (m_ld_cnt >= 1) ld_valid = 1'b0;
            if (m_core_cnt >= 2) begin
                req_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) note_fail("arb_sequence");
        chk("arb_ld_after_core", m_last_ld_cyc - m_first_core, 3);
        chk("arb_core_again", m_last_core_cyc - m_first_core, 4);
        do_req(0, 3'b100, 32'h30, 0, 0, rd, er, lat);
        chk("lbu_loader_byte", rd, 32'h0000005A);
        do_req(0, 3'b100, 32'h31, 0, 0, rd, er, lat);
        chk("lbu_core_byte", rd, 32'h00000011);

        // word store and load back, inputs scrambled after accept
        do_req(1, 3'b010, 32'h10, 32'hA1B2C3D4, 1, rd, er, lat);
        chk("sw_rdata", rd, 0);
        chk("sw_err", er, 0);
        chk("sw_latency", lat, 5);
        chk("sram_10", sram[12'h010], 8'hD4);
        chk("sram_11", sram[12'h011], 8'hC3);
        chk("sram_12", sram[12'h012], 8'hB2);
        chk("sram_13", sram[12'h013], 8'hA1);
        do_req(0, 3'b010, 32'h10, 32'h0, 1, rd, er, lat);
        chk("lw_rdata", rd, 32'hA1B2C3D4);
        chk("lw_latency", lat, 6);
        chk("lw_model", m_exp, 32'hA1B2C3D4);

        // byte and half extension
        do_req(1, 3'b000, 32'h21, 32'h12345680, 0, rd, er, lat);
        chk("sb_latency", lat, 2);
        do_req(0, 3'b000, 32'h21, 0, 0, rd, er, lat);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        chk("lb_latency", lat, 3);
        do_req(0, 3'b100, 32'h21, 0, 0, rd, er, lat);
        chk("lbu_rdata", rd, 32'h00000080);
        do_req(1, 3'b001, 32'h22, 32'hCAFE8001, 0, rd, er, lat);
        chk("sh_latency", lat, 3);
        do_req(0, 3'b001, 32'h22, 0, 0, rd, er, lat);
        chk("lh_rdata", rd, 32'hFFFF8001);
        chk("lh_latency", lat, 4);
        chk("lh_model", m_exp, 32'hFFFF8001);
        do_req(0, 3'b101, 32'h22, 0, 0, rd, er, lat);
        chk("lhu_rdata", rd, 32'h00008001);

        // unsigned flag on a store is not an error
        do_req(1, 3'b100, 32'h50, 32'h0000007F, 0, rd, er, lat);
        chk("sbu_err", er, 0);
        do_req(0, 3'b000, 32'h50, 0, 0, rd, er, lat);
        chk("lb_positive", rd, 32'h0000007F);

        // error responses
        do_req(0, 3'b010, 32'h12, 0, 0, rd, er, lat);
        chk("lw_mis_err", er, 1);
        chk("lw_mis_lat", lat, 1);
        chk("lw_mis_rdata", rd, 0);
        do_req(0, 3'b001, 32'h13, 0, 0, rd, er, lat);
        chk("lh_mis_err", er, 1);
        chk("lh_mis_rdata", rd, 0);
        do_req(0, 3'b011, 32'h0, 0, 0, rd, er, lat);
        chk("size3_err", er, 1);
        chk("size3_lat", lat, 1);
        do_req(0, 3'b010, 32'h00001000, 0, 0, rd, er, lat);
        chk("range_err", er, 1);
        chk("range_lat", lat, 1);

        // reset during beat 2 of a word store
        wait_idle();
        r0 = m_core_cnt;
        req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK); #1;
            if (m_core_cnt != r0) begin done = 1; break; end
        end
        if (!done) note_fail("rst_mid_accept");
        a = m_last_core_cyc;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK); #1;
            req_valid = 1'b0;
            if (cyc == a + 3) break;
        end
        RST = 1'b1;
        r0 = obs_cnt;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK); #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mem_en", mem_en, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        repeat (8) @(negedge CLK);
        #1;
        chk("rst_mid_no_rsp", obs_cnt - r0, 0);
        do_req(0, 3'b010, 32'h10, 0, 0, rd, er, lat);
        chk("post_rst_lw", rd, 32'hA1B2C3D4);

        repeat (3) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
